// File: rtl/score_tracker.sv
// Score/hit tracker for the rock-dodge game: counts dodges and hits, runs the
// post-hit flash window and exposes the game phase.
module score_tracker #(
    parameter int WIN_SCORE = 15,
    parameter int MAX_MISS  = 15,
    parameter int FLASH_MS  = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       start,
    input  logic       rock_pass,
    input  logic [1:0] rock_lane,
    input  logic [1:0] player_lane,
    output logic [4:0] scoreCounter,
    output logic [4:0] gameOver,
    output logic       hit_flash,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        FLASH = 2'b10,
        DONE  = 2'b11
    } phase_e;

    localparam logic [4:0] WIN_C   = 5'(WIN_SCORE);
    localparam logic [4:0] MAX_C   = 5'(MAX_MISS);
    localparam logic [9:0] FLASH_C = 10'(FLASH_MS);

    phase_e     state_q, state_d;
    logic [4:0] score_q, score_d;
    logic [4:0] miss_q, miss_d;
    logic [9:0] flash_q, flash_d;
    logic       hit_flash_q, hit_flash_d;
    logic       start_q;
    logic       armed_q;
    logic       start_rise;

    // armed_q only sets once start has been seen low, so a start level held
    // through reset release is never taken as a rising edge.
    assign start_rise = start && !start_q && armed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score_q     <= 5'd0;
            miss_q      <= 5'd0;
            flash_q     <= 10'd0;
            hit_flash_q <= 1'b0;
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            flash_q     <= flash_d;
            hit_flash_q <= hit_flash_d;
            start_q     <= start;
            if (!start) armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        miss_d  = miss_q;
        flash_d = flash_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    score_d = 5'd0;
                    miss_d  = 5'd0;
                    flash_d = 10'd0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (rock_pass) begin
                    if (rock_lane != player_lane) begin
                        if (score_q < WIN_C) score_d = score_q + 5'd1;
                        if (score_d == WIN_C) state_d = DONE;
                    end else begin
                        if (miss_q < MAX_C) miss_d = miss_q + 5'd1;
                        if (miss_d == MAX_C) begin
                            state_d = DONE;
                            flash_d = 10'd0;
                        end else begin
                            state_d = FLASH;
                            flash_d = FLASH_C;
                        end
                    end
                end
            end
            FLASH: begin
                if (clk_1ms) begin
                    flash_d = (flash_q > 10'd1) ? flash_q - 10'd1 : 10'd0;
                    if (flash_d == 10'd0) state_d = PLAY;
                end
                // Invulnerable while flashing; a win here overrides the flash return.
                if (rock_pass) begin
                    if (score_q < WIN_C) score_d = score_q + 5'd1;
                    if (score_d == WIN_C) begin
                        state_d = DONE;
                        flash_d = 10'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                flash_d = 10'd0;
            end
        endcase
        hit_flash_d = (state_d == FLASH);
    end

    assign scoreCounter = score_q;
    assign gameOver     = miss_q;
    assign hit_flash    = hit_flash_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: drivers push expected outputs, a
// negedge monitor pops and compares them.
module tb_score_tracker;

    localparam logic [1:0] P_IDLE  = 2'b00;
    localparam logic [1:0] P_PLAY  = 2'b01;
    localparam logic [1:0] P_FLASH = 2'b10;
    localparam logic [1:0] P_DONE  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_1ms = 1'b0;
    logic       start = 1'b0;
    logic       rock_pass = 1'b0;
    logic [1:0] rock_lane = 2'd0;
    logic [1:0] player_lane = 2'd0;
    logic [4:0] scoreCounter;
    logic [4:0] gameOver;
    logic       hit_flash;
    logic [1:0] phase;

    logic [12:0] exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          failed = 0;

    score_tracker #(.WIN_SCORE(15), .MAX_MISS(15), .FLASH_MS(100)) dut (
        .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .start(start),
        .rock_pass(rock_pass), .rock_lane(rock_lane), .player_lane(player_lane),
        .scoreCounter(scoreCounter), .gameOver(gameOver),
        .hit_flash(hit_flash), .phase(phase)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock at most, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            logic [12:0] got;
            string       n;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = {phase, hit_flash, gameOver, scoreCounter};
            tests++;
            if (got !== e) begin
                failed++;
                $display("FAIL %s: got ph=%b hf=%b go=%0d sc=%0d, expected ph=%b hf=%b go=%0d sc=%0d",
                         n, got[12:11], got[10], got[9:5], got[4:0],
                         e[12:11], e[10], e[9:5], e[4:0]);
            end
        end
    end

    task automatic step(input logic st, input logic rp, input logic [1:0] rl,
                        input logic [1:0] pl, input logic ms,
                        input logic [1:0] eph, input logic ehf,
                        input logic [4:0] ego, input logic [4:0] esc, input string nm);
        start       = st;
        rock_pass   = rp;
        rock_lane   = rl;
        player_lane = pl;
        clk_1ms     = ms;
        @(posedge clk);
        #1;
        rock_pass = 1'b0;
        clk_1ms   = 1'b0;
        exp_q.push_back({eph, ehf, ego, esc});
        name_q.push_back(nm);
    endtask

    task automatic chk_now(input string nm, input logic [12:0] e);
        logic [12:0] got;
        got = {phase, hit_flash, gameOver, scoreCounter};
        tests++;
        if (got !== e) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", nm, got, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and ignored rock in IDLE
        #12;
        chk_now("reset_state", 13'd0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 2'd2, 2'd0, 0, P_IDLE, 0, 5'd0, 5'd0, "idle_ignores_rock");
        step(1, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd0, "start_to_play");

        // Three dodges
        for (int i = 1; i <= 3; i++)
            step(1, 1, 2'd2, 2'd0, 0, P_PLAY, 0, 5'd0, 5'(i), "dodge");

        // Start edges mid-game are ignored, with and without rock_pass
        step(0, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd3, "start_fall_play");
        step(1, 1, 2'd3, 2'd1, 0, P_PLAY, 0, 5'd0, 5'd4, "start_edge_with_rock");
        step(0, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd4, "start_fall_play2");
        step(1, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd4, "start_edge_no_rock");

        // Hit, invulnerable rock during flash, then exactly 100 ms pulses
        step(1, 1, 2'd1, 2'd1, 0, P_FLASH, 1, 5'd1, 5'd4, "hit_to_flash");
        step(1, 1, 2'd1, 2'd1, 0, P_FLASH, 1, 5'd1, 5'd5, "flash_same_lane_dodge");
        for (int p = 1; p <= 100; p++) begin
            if (p < 100) begin
                step(1, 0, 2'd0, 2'd1, 1, P_FLASH, 1, 5'd1, 5'd5, "flash_tick");
                step(1, 0, 2'd0, 2'd1, 0, P_FLASH, 1, 5'd1, 5'd5, "flash_idle_cycle");
            end else begin
                step(1, 0, 2'd0, 2'd1, 1, P_PLAY, 0, 5'd1, 5'd5, "flash_return");
            end
        end

        // Win by dodging
        for (int k = 6; k <= 14; k++)
            step(1, 1, 2'd0, 2'd3, 0, P_PLAY, 0, 5'd1, 5'(k), "dodge_to_14");
        step(1, 1, 2'd0, 2'd3, 0, P_DONE, 0, 5'd1, 5'd15, "win_done");
        step(1, 1, 2'd0, 2'd3, 0, P_DONE, 0, 5'd1, 5'd15, "done_freeze_dodge");
        step(1, 1, 2'd3, 2'd3, 0, P_DONE, 0, 5'd1, 5'd15, "done_freeze_hit");
        step(0, 0, 2'd0, 2'd0, 0, P_DONE, 0, 5'd1, 5'd15, "done_start_fall");
        step(1, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd0, "done_restart");

        // Lose by 15 hits
        for (int h = 1; h <= 14; h++) begin
            step(1, 1, 2'd2, 2'd2, 0, P_FLASH, 1, 5'(h), 5'd0, "hit_n");
            for (int p = 1; p <= 100; p++) begin
                if (p < 100)
                    step(1, 0, 2'd0, 2'd2, 1, P_FLASH, 1, 5'(h), 5'd0, "loss_flash_tick");
                else
                    step(1, 0, 2'd0, 2'd2, 1, P_PLAY, 0, 5'(h), 5'd0, "loss_flash_return");
            end
        end
        step(1, 1, 2'd2, 2'd2, 0, P_DONE, 0, 5'd15, 5'd0, "loss_done");
        step(1, 1, 2'd2, 2'd2, 0, P_DONE, 0, 5'd15, 5'd0, "loss_freeze");

        // Winning dodge from FLASH beats the flash return
        step(0, 0, 2'd0, 2'd0, 0, P_DONE, 0, 5'd15, 5'd0, "loss_start_fall");
        step(1, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd0, "loss_restart");
        for (int k = 1; k <= 14; k++)
            step(1, 1, 2'd1, 2'd0, 0, P_PLAY, 0, 5'd0, 5'(k), "dodge_game3");
        step(1, 1, 2'd0, 2'd0, 0, P_FLASH, 1, 5'd1, 5'd14, "hit_game3");
        step(1, 1, 2'd0, 2'd0, 1, P_DONE, 0, 5'd1, 5'd15, "flash_win_done");

        // Asynchronous reset during FLASH with the flash counter at 100
        step(0, 0, 2'd0, 2'd0, 0, P_DONE, 0, 5'd1, 5'd15, "g4_start_fall");
        step(1, 0, 2'd0, 2'd0, 0, P_PLAY, 0, 5'd0, 5'd0, "g4_restart");
        step(1, 1, 2'd3, 2'd3, 0, P_FLASH, 1, 5'd1, 5'd0, "g4_hit");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_now("async_reset_flash", 13'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1, 1, 2'd0, 2'd1, 1, P_IDLE, 0, 5'd0, 5'd0, "start_held_after_reset");
        step(0, 1, 2'd0, 2'd1, 0, P_IDLE, 0, 5'd0, 5'd0, "start_low_after_reset");
        step(1, 1, 2'd0, 2'd1, 0, P_PLAY, 0, 5'd0, 5'd0, "fresh_start_edge");
        step(1, 1, 2'd0, 2'd1, 0, P_PLAY, 0, 5'd0, 5'd1, "dodge_after_reset");

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter WIN_SCORE, default 15: score at which the player wins.
REQ-002 Parameter MAX_MISS, default 15: hit count at which the game is lost.
REQ-003 Parameter FLASH_MS, default 250: length of the post-hit flash window, in clk_1ms ticks (1..1023).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous active-low reset.
REQ-007 Port clk_1ms, input, 1: single-clk-cycle enable pulse, once per millisecond; not a clock.
REQ-008 Port start, input, 1: active-high start button level, already synchronised to clk.
REQ-009 Port rock_pass, input, 1: single-cycle pulse; a rock has reached the player row.
REQ-010 Port rock_lane, input, 2: lane of the rock that is passing; valid only while rock_pass=1.
REQ-011 Port player_lane, input, 2: current player lane.
REQ-012 Port scoreCounter, output, 5: rocks dodged in the current game.
REQ-013 Port gameOver, output, 5: rocks hit in the current game.
REQ-014 Port hit_flash, output, 1: high during the post-hit flash window.
REQ-015 Port phase, output, 2: FSM state (00 IDLE, 01 PLAY, 10 FLASH, 11 DONE).

Function
REQ-016 The block SHALL detect a start rising edge (start=1 this cycle, 0 the previous cycle) using a registered copy of start.
REQ-017 IDLE: on a start rising edge, clear both counters and go to PLAY on the next clk edge; ignore rock_pass.
REQ-018 PLAY, rock_pass=1 and rock_lane != player_lane: increment scoreCounter by 1 and stay in PLAY.
REQ-019 PLAY, rock_pass=1 and rock_lane == player_lane: increment gameOver by 1, load the flash counter with FLASH_MS, and go to FLASH.
REQ-020 FLASH: hit_flash=1. Decrement the flash counter only on cycles with clk_1ms=1. When a decrement reaches 0, return to PLAY on that edge.
REQ-021 FLASH: treat any rock_pass as a dodge regardless of lane (invulnerability); increment scoreCounter.
REQ-022 When scoreCounter reaches WIN_SCORE, or gameOver reaches MAX_MISS, go to DONE in that same edge, with the final counter values registered.
REQ-023 If one rock_pass drives a counter to its limit from FLASH, go to DONE; DONE takes priority over the flash return.
REQ-024 DONE: freeze both counters; hit_flash=0; ignore rock_pass. A start rising edge clears both counters and goes to PLAY.
REQ-025 Counters SHALL saturate: never exceed WIN_SCORE or MAX_MISS, and never wrap.
REQ-026 At most one counter changes per cycle, and by at most 1.
REQ-027 In PLAY or FLASH, a start edge in the same cycle as rock_pass SHALL be ignored; rock_pass is processed.
REQ-028 In PLAY or FLASH, a start edge without rock_pass SHALL be ignored; there is no mid-game restart.
REQ-029 All outputs SHALL be registered. Counter and phase updates are visible the cycle after the qualifying input; latency is 1 clk.
REQ-030 phase SHALL be 00 only in IDLE; no illegal FSM encodings are reachable. Any unreachable encoding recovers to IDLE.

Reset
REQ-031 While reset=0: scoreCounter=0, gameOver=0, hit_flash=0, phase=00 (IDLE), flash counter=0, start history register=0, all asynchronously.
REQ-032 Reset asserted mid-game (PLAY, FLASH or DONE) SHALL abort the game immediately, with no completion of pending updates.
REQ-033 After reset deasserts, a new start rising edge is required before any counting.
REQ-034 A start held high through reset deassertion SHALL NOT count as a rising edge.

Verification
REQ-035 Reset, start 0->1, then 3 rock_pass pulses with rock_lane=2, player_lane=0 -> scoreCounter=3, gameOver=0, phase=01.
REQ-036 In PLAY, rock_pass with rock_lane=player_lane=1 -> gameOver=1 and phase=10 next cycle. hit_flash stays 1 for exactly FLASH_MS clk_1ms pulses, then phase=01. A same-lane rock_pass during the window increments scoreCounter only.
REQ-037 With 14 dodges, a 15th dodge -> scoreCounter=15, phase=11. Further rock_pass pulses leave both counters unchanged; a new start edge -> counters 0, phase=01.
REQ-038 With 14 hits (FLASH_MS=2 for speed), a 15th hit -> gameOver=15, phase=11, hit_flash=0 (not FLASH).
REQ-039 Assert reset during FLASH with the flash counter at 100 -> all outputs zero and phase=00 asynchronously. After release with start held high, no transition until start falls and rises again.
REQ-040 In PLAY, rock_pass and a start edge in the same cycle -> exactly one counter increments and the game does not restart.
